ps2_rx_fifo: RTL
================

// Module: ps2_rx_fifo
// PURPOSE
//   Parametrised PS/2 keyboard receiver with a frame checker, a make/break/extended
//   scan-code decoder and an output FIFO. Sits between the board PS/2 pins and the
//   NPC keyboard MMIO device. The CPU drains decoded key events through a
//   valid/ready port, so it can poll slowly without losing keystrokes.
// PARAMETERS
//   FIFO_DEPTH      8      FIFO entries; power of 2, >= 2
//   SYNC_STAGES     3      synchroniser flops on ps2_clk and ps2_data; >= 2
//   TIMEOUT_CYCLES  50000  clk cycles with no ps2_clk fall mid-frame before the frame is aborted
//   DECODE_PREFIX   1      1: absorb 0xE0/0xF0 prefixes into flags; 0: push every byte raw
// PORTS
//   clk         in   1        system clock
//   resetn      in   1        reset, synchronous, active-low
//   ps2_clk     in   1        async PS/2 clock pin
//   ps2_data    in   1        async PS/2 data pin
//   out_valid   out  1        FIFO head valid (FIFO not empty)
//   out_ready   in   1        consumer accepts head when out_valid & out_ready
//   out_data    out  8        scan code at FIFO head
//   out_break   out  1        head is a break (key release) code
//   out_ext     out  1        head is an extended (E0-prefixed) code
//   out_count   out  CW       entries in FIFO, CW = $clog2(FIFO_DEPTH)+1
//   parity_err  out  1        1-cycle pulse: frame rejected for parity
//   frame_err   out  1        1-cycle pulse: bad start/stop bit, or timeout abort
//   overflow    out  1        sticky: a good byte was dropped because the FIFO was full
// BEHAVIOUR
//   Reset: all outputs 0, FIFO empty, FSM IDLE, bit counter 0, prefix flags 0.
//     Reset mid-frame discards the partial frame.
//   Sync: ps2_clk and ps2_data each pass through SYNC_STAGES flops.
//     sample = falling edge of synced clk (prev=1, cur=0).
//     Data is taken from the synced ps2_data in the same cycle.
//   Frame: 11 bits = start(0), d[0..7] LSB first, parity (odd over d+parity), stop(1).
//   FSM:
//     - IDLE: on sample with data=0, go to RECV with bitcnt=1.
//       A sample with data=1 is ignored (no error).
//     - RECV: on each sample, shift in the bit and increment bitcnt.
//     - When the 11th bit (stop) is sampled, go to IDLE and check the frame:
//         stop != 1           -> frame_err
//         else parity bad     -> parity_err
//         else                -> good byte
//     - RECV timeout: a cycle counter is cleared on every sample. When it reaches
//       TIMEOUT_CYCLES: frame_err pulse, FSM to IDLE, bitcnt=0.
//   Error pulses: asserted the cycle after the sampling cycle of the terminating bit
//     or timeout. Any error frame also clears both prefix flags.
//   Decode (DECODE_PREFIX=1):
//     - good 0xE0 -> ext_pend=1, no push.
//     - good 0xF0 -> brk_pend=1, no push.
//     - any other good byte -> push {byte, brk_pend, ext_pend}, then clear both flags.
//   Decode (DECODE_PREFIX=0): every good byte is pushed with break=ext=0.
//   Latency: pushed entry is visible (out_valid=1, out_count incremented) the cycle
//     after the stop-bit sampling cycle.
//   FIFO:
//     - first-word-fall-through; out_data/out_break/out_ext = head entry; 0 when empty.
//     - pop = out_valid & out_ready. Pop when empty is ignored.
//     - Read and write pointers wrap modulo FIFO_DEPTH.
//     - push when full and no pop: entry dropped, overflow set; it stays set until reset.
//     - push when full with pop in the same cycle: accepted, out_count unchanged.
//     - push and pop in the same cycle when not full/empty: both occur, out_count unchanged.
//     - push into an empty FIFO: the new entry is not visible at the head until the
//       next cycle.
// TESTING
//   1. Frame 0x1C with correct parity, out_ready=1 -> one cycle later out_valid=1,
//      out_data=0x1C, brk=0, ext=0; popped the following cycle.
//   2. Frames F0,1C -> exactly one entry: data=0x1C, out_break=1, out_ext=0.
//      Frames E0,F0,75 -> one entry: data=0x75, break=1, ext=1.
//   3. Frame 0x1C with a flipped parity bit -> parity_err pulse, no push, count 0.
//      Frame with stop=0 -> frame_err pulse, no push.
//   4. out_ready=0, send 9 good bytes (0x01..0x09) -> out_count=8, overflow=1;
//      draining yields 0x01..0x08 in order.
//   5. Send start plus 4 bits, then silence for TIMEOUT_CYCLES -> frame_err pulse;
//      the next full frame 0x29 is received correctly.
//   6. Assert resetn=0 after 6 bits of a frame, then release -> all outputs 0;
//      the next frame 0x5A is received intact. With DECODE_PREFIX=0, F0 then 1C
//      -> two raw entries.

Source files
------------

// File: rtl/ps2_rx_fifo.sv
// PS/2 keyboard receiver: synchroniser, frame checker, make/break/extended
// prefix decoder and a first-word-fall-through key event FIFO.
module ps2_rx_fifo #(
  parameter int FIFO_DEPTH     = 8,
  parameter int SYNC_STAGES    = 3,
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int DECODE_PREFIX  = 1,
  localparam int CW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          ps2_clk,
  input  logic          ps2_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [7:0]    out_data,
  output logic          out_break,
  output logic          out_ext,
  output logic [CW-1:0] out_count,
  output logic          parity_err,
  output logic          frame_err,
  output logic          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic {IDLE, RECV} state_t;

  logic [SYNC_STAGES-1:0] kc;
  logic [SYNC_STAGES-1:0] kd;
  logic                   kprev;
  logic                   sample;
  logic                   din;

  state_t        state;
  logic [3:0]    bitcnt;
  logic [8:0]    sr;
  logic [TW-1:0] tcnt;
  logic          ext_pend;
  logic          brk_pend;

  logic          stop_bit;
  logic          par_ok;
  logic          good;
  logic          is_pfx;
  logic          push_req;
  logic [9:0]    entry;

  logic [9:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          full;
  logic          pop;
  logic          wr;

  // Idle bus is high, so the chain resets to 1 to avoid a fake edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      kc    <= '1;
      kd    <= '1;
      kprev <= 1'b1;
    end else begin
      kc    <= {kc[SYNC_STAGES-2:0], ps2_clk};
      kd    <= {kd[SYNC_STAGES-2:0], ps2_data};
      kprev <= kc[SYNC_STAGES-1];
    end
  end

  assign sample = kprev & ~kc[SYNC_STAGES-1];
  assign din    = kd[SYNC_STAGES-1];

  assign stop_bit = sample && (state == RECV) && (bitcnt == 4'd10);
  assign par_ok   = ^sr;
  assign good     = stop_bit & din & par_ok;
  assign is_pfx   = (DECODE_PREFIX != 0) &&
                    ((sr[7:0] == 8'hE0) || (sr[7:0] == 8'hF0));
  assign push_req = good & ~is_pfx;
  assign entry    = {sr[7:0], brk_pend, ext_pend};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= IDLE;
      bitcnt     <= '0;
      sr         <= '0;
      tcnt       <= '0;
      ext_pend   <= 1'b0;
      brk_pend   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          tcnt <= '0;
          if (sample && !din) begin
            state  <= RECV;
            bitcnt <= 4'd1;
          end
        end
        RECV: begin
          if (sample) begin
            tcnt <= '0;
            if (bitcnt == 4'd10) begin
              state  <= IDLE;
              bitcnt <= '0;
              if (!din) frame_err <= 1'b1;
              else if (!par_ok) parity_err <= 1'b1;
              if (!good) begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
              end else if (is_pfx && sr[7:0] == 8'hE0) begin
                ext_pend <= 1'b1;
              end else if (is_pfx) begin
                brk_pend <= 1'b1;
              end else begin
                ext_pend <= 1'b0;
                brk_pend <= 1'b0;
              end
            end else begin
              sr     <= {din, sr[8:1]};
              bitcnt <= bitcnt + 4'd1;
            end
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state     <= IDLE;
            bitcnt    <= '0;
            tcnt      <= '0;
            frame_err <= 1'b1;
            ext_pend  <= 1'b0;
            brk_pend  <= 1'b0;
          end else begin
            tcnt <= tcnt + TW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign out_valid = (out_count != '0);
  assign full      = (out_count == CW'(FIFO_DEPTH));
  assign pop       = out_valid & out_ready;
  assign wr        = push_req & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= entry;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wp        <= '0;
      rp        <= '0;
      out_count <= '0;
      overflow  <= 1'b0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      if (wr && !pop) out_count <= out_count + CW'(1);
      else if (pop && !wr) out_count <= out_count - CW'(1);
      if (push_req && full && !pop) overflow <= 1'b1;
    end
  end

  assign out_data  = out_valid ? mem[rp][9:2] : 8'h00;
  assign out_break = out_valid & mem[rp][1];
  assign out_ext   = out_valid & mem[rp][0];

endmodule
